// File: rtl/alu_sequencer.sv
// Multi-cycle command sequencer that drives the MINI_CPU combinational ALU.
// Optional response counter on op_count is enabled by defining ALU_SEQ_OP_COUNT_EN.
module alu_sequencer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREGS  = 4,
    localparam int unsigned RA_W  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [RA_W-1:0]   cmd_rd,
    input  logic [RA_W-1:0]   cmd_rs1,
    input  logic [RA_W-1:0]   cmd_rs2,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_op_a,
    output logic [DATA_W-1:0] alu_op_b,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic              zero_flag,
    output logic [15:0]       op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_LOADI = 3'b100;
    localparam logic [2:0] OP_READ  = 3'b101;

    state_t state, next_state;

    logic [2:0]        op_q;
    logic [RA_W-1:0]   rd_q;
    logic [RA_W-1:0]   rs1_q;
    logic [RA_W-1:0]   rs2_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] regs [NREGS];

    logic op_illegal;
    logic op_writes;

    assign op_illegal = (op_q[2:1] == 2'b11);
    assign op_writes  = !op_q[2] || (op_q == OP_LOADI);

    // Gated by rst_n so the handshake is closed while reset is held.
    assign cmd_ready = (state == IDLE) && rst_n;
    assign rsp_valid = (state == RESP);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cmd_valid) next_state = EXEC;
            EXEC:    next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        alu_op_a = '0;
        alu_op_b = '0;
        alu_op   = 2'b00;
        if (state == EXEC) begin
            case (op_q)
                3'b000, 3'b001, 3'b010, 3'b011: begin
                    alu_op_a = regs[rs1_q];
                    alu_op_b = regs[rs2_q];
                    alu_op   = op_q[1:0];
                end
                OP_LOADI: alu_op_a = imm_q;
                OP_READ:  alu_op_a = regs[rs1_q];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
            zero_flag <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        rd_q  <= cmd_rd;
                        rs1_q <= cmd_rs1;
                        rs2_q <= cmd_rs2;
                        imm_q <= cmd_imm;
                    end
                end
                EXEC: begin
                    if (op_illegal) begin
                        rsp_data <= '0;
                        rsp_zero <= 1'b0;
                        rsp_err  <= 1'b1;
                    end else begin
                        rsp_data <= alu_result;
                        rsp_zero <= alu_zero;
                        rsp_err  <= 1'b0;
                        if (op_writes) begin
                            regs[rd_q] <= alu_result;
                            zero_flag  <= alu_zero;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_SEQ_OP_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (rsp_valid && rsp_ready) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign op_count = count_q;
`else
    assign op_count = '0;
`endif

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle command sequencer that acts as the initiator for the MINI_CPU 8-bit ALU.
- Accepts register-level commands over a valid/ready handshake and reads operands from a small internal register file.
- Drives the ALU's op_a/op_b/alu_op, captures result/zero, writes back, then returns a response over a second valid/ready handshake.
- Sits between the CPU front end (command source) and the combinational ALU.

Parameters:
- DATA_W, 8, datapath width; must match the ALU operand width.
- NREGS, 4, number of general registers; register address width RA_W = $clog2(NREGS).

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 LOADI, 101 READ, 110/111 illegal
- cmd_rd  input  RA_W  destination register
- cmd_rs1  input  RA_W  source A / register to READ
- cmd_rs2  input  RA_W  source B
- cmd_imm  input  DATA_W  immediate for LOADI
- alu_op_a  output  DATA_W  to ALU op_a
- alu_op_b  output  DATA_W  to ALU op_b
- alu_op  output  2  to ALU alu_op
- alu_result  input  DATA_W  from ALU result
- alu_zero  input  1  from ALU zero
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  DATA_W  result of completed command
- rsp_zero  output  1  ALU zero for completed command
- rsp_err  output  1  completed command was illegal
- zero_flag  output  1  sticky zero flag of last register write
- op_count  output  16  completed-response counter (see Optional Feature)

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n). Reset is sampled on the clk rising edge only.
- Reset values (and any rst_n=0 edge, including mid-command):
  - state=IDLE, all registers=0, zero_flag=0.
  - cmd_ready=0 during reset, 1 in the first cycle after reset.
  - rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_err=0, op_count=0.
  - An in-flight command is dropped with no writeback.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch all cmd_* fields and go to EXEC.
  - EXEC (exactly 1 cycle): drive the ALU from the latched command and regfile values read this cycle (ALU is combinational).
    - ADD/SUB/AND/OR: op_a=R[rs1], op_b=R[rs2], alu_op=cmd_op[1:0].
    - LOADI: op_a=imm, op_b=0, alu_op=00.
    - READ: op_a=R[rs1], op_b=0, alu_op=00.
    - At the EXEC clock edge:
      - Capture rsp_data=alu_result and rsp_zero=alu_zero.
      - ALU ops and LOADI write R[rd]=alu_result and zero_flag=alu_zero.
      - READ performs no register write and leaves zero_flag unchanged.
    - Go to RESP.
  - Illegal op: the ALU is driven with zeros. At the EXEC edge, rsp_data=0, rsp_zero=0, rsp_err=1; no register write; zero_flag unchanged.
  - RESP: rsp_valid=1. rsp_* remain stable until rsp_valid&&rsp_ready. On handshake, clear rsp_valid and go to IDLE.
- Outside EXEC, alu_op_a=0, alu_op_b=0, alu_op=00.
- Latency:
  - Command accepted at edge T → rsp_valid high in the cycle after edge T+1.
  - With rsp_ready held at 1, the next command can be accepted at edge T+3.
  - Throughput: 1 command per 3 cycles.
- cmd_ready=0 in EXEC and RESP; cmd_* inputs are ignored there.
- Hazards:
  - rd equal to rs1 or rs2: operands are the pre-write values; the write lands at the EXEC edge.
  - Back-to-back dependent commands always see the previous write, since writeback precedes the next accept.
- Arithmetic: wrap modulo 2^DATA_W. The ALU itself provides the wrap (e.g. 0x00−0x01=0xFF, 0xFF+0x01=0x00 with zero=1).
- Backpressure: rsp_ready may stay low indefinitely; the block holds RESP with rsp_* unchanged.

Optional Feature:
- Macro: ALU_SEQ_OP_COUNT_EN.
- When defined:
  - op_count is a 16-bit counter, incremented by 1 on every response handshake (rsp_valid&&rsp_ready), including illegal ops.
  - Wraps 0xFFFF→0x0000.
  - Reset to 0.
- When undefined: op_count is tied to 0 and no counter flops exist. The port is always present.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 edges with cmd_valid=1 → cmd_ready=0, rsp_valid=0, no writes. After release, cmd_ready=1.
- LOADI and ADD:
  - LOADI R1=0x05 → rsp_data=0x05, rsp_zero=0.
  - LOADI R2=0xFB, then ADD R3=R1+R2 → rsp_data=0x00, rsp_zero=1, zero_flag=1.
  - READ R3 → 0x00. rsp_valid timing matches the 2-edge latency.
- SUB wrap and logic:
  - R1=0x00, R2=0x01, SUB R0=R1−R2 → 0xFF.
  - AND 0xF0&0x0F → 0x00 (zero=1).
  - OR 0xF0|0x0F → 0xFF.
  - alu_op observed as 01/10/11 only during EXEC.
- Hazard: R1=0x03; ADD R1=R1+R1 → 0x06; READ R1 → 0x06.
- Backpressure and illegal:
  - Issue cmd_op=110 with rsp_ready=0 for 5 cycles → rsp_valid held, rsp_err=1, rsp_data=0, cmd_ready=0 throughout, zero_flag and registers unchanged.
  - Then rsp_ready=1 → IDLE next cycle.
- Reset mid-op and counter:
  - Assert rst_n=0 during EXEC of ADD → target register=0, rsp_valid=0.
  - With ALU_SEQ_OP_COUNT_EN, 3 completed responses → op_count=3; without the macro → op_count=0.
